// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reset_sequencer_pkg                                        |
// | Purpose : Shared definitions for the staged reset sequencer: FSM     |
// |           state encoding and a constant-evaluable ceil(log2).        |
// | Ports   : none (package)                                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_GAP      = 3'd2,
    ST_RUN      = 3'd3,
    ST_TEARDOWN = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // ceil(log2(value)), never less than 1 so vectors stay legal.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reset_seq_timer                                            |
// | Purpose : Shared cycle counter used for lock debounce, inter-stage   |
// |           gap and ack timeout.                                       |
// | Ports   : clk, sync_rst_n  - clock, synchronous active-low reset     |
// |           clr              - force count to zero (wins over en)      |
// |           en               - increment count                         |
// |           terminal         - compare value                           |
// |           at_terminal      - count equals terminal                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reset_seq_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_terminal = (cnt == terminal);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reset_sequencer                                            |
// | Purpose : Staged reset controller. Waits for a debounced PLL lock,   |
// |           releases stage resets one at a time in index order gated   |
// |           by each stage's init ack, tears them down in reverse order |
// |           on lock loss or software request, and latches a sticky     |
// |           fault on an ack timeout.                                   |
// | Ports   : clk, sync_rst_n  - clock, synchronous active-low reset     |
// |           pll_locked       - PLL lock (synchronous to clk)           |
// |           sw_reset_req     - 1-cycle restart / fault-clear pulse     |
// |           stage_ack        - per-stage init-done level               |
// |           stage_rst_n      - per-stage active-low reset (thermometer)|
// |           seq_done         - all stages released and acked           |
// |           fault            - sticky ack-timeout flag                 |
// |           fault_stage      - index of the stage that timed out       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int ACK_TIMEOUT = 1024,
  localparam int CNT_W = clog2((STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT),
  localparam int IDX_W = clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  sync_rst_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic                  fault,
  output logic [IDX_W-1:0]      fault_stage
);

  localparam logic [CNT_W-1:0]      GAP_LAST    = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]      ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic [NUM_STAGES-1:0]   stage_rst_nx;
  logic                    seq_done_nx;
  logic                    fault_nx;
  logic [IDX_W-1:0]        fault_stage_nx;
  logic                    tmr_clr, tmr_en, tmr_hit;
  logic [CNT_W-1:0]        tmr_term;
  logic                    abort;

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .clr         (tmr_clr),
    .en          (tmr_en),
    .terminal    (tmr_term),
    .at_terminal (tmr_hit)
  );

  assign abort = !pll_locked || sw_reset_req;

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state       <= ST_HOLD;
      idx         <= '0;
      stage_rst_n <= '0;
      seq_done    <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      stage_rst_n <= stage_rst_nx;
      seq_done    <= seq_done_nx;
      fault       <= fault_nx;
      fault_stage <= fault_stage_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    idx_nx         = idx;
    stage_rst_nx   = stage_rst_n;
    seq_done_nx    = seq_done;
    fault_nx       = fault;
    fault_stage_nx = fault_stage;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    tmr_term       = GAP_LAST;

    unique case (state)
      ST_HOLD: begin
        // Any lock drop or software request restarts the debounce window.
        if (abort) begin
          tmr_clr = 1'b1;
        end else if (tmr_hit) begin
          state_nx     = ST_WAIT_ACK;
          stage_rst_nx = FIRST_STAGE;
          tmr_clr      = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        tmr_term = ACK_LAST;
        if (abort) begin
          state_nx    = ST_TEARDOWN;
          seq_done_nx = 1'b0;
        end else if (stage_ack[idx]) begin
          tmr_clr = 1'b1;
          if (idx == LAST_IDX) begin
            state_nx    = ST_RUN;
            seq_done_nx = 1'b1;
          end else begin
            state_nx = ST_GAP;
          end
        end else if (tmr_hit) begin
          state_nx       = ST_FAULT;
          fault_nx       = 1'b1;
          fault_stage_nx = idx;
          stage_rst_nx   = '0;
          seq_done_nx    = 1'b0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_GAP: begin
        if (abort) begin
          state_nx    = ST_TEARDOWN;
          seq_done_nx = 1'b0;
        end else if (tmr_hit) begin
          // Shifting a 1 in from the bottom keeps the thermometer shape.
          state_nx     = ST_WAIT_ACK;
          idx_nx       = idx + IDX_W'(1);
          stage_rst_nx = {stage_rst_n[NUM_STAGES-2:0], 1'b1};
          tmr_clr      = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_nx    = ST_TEARDOWN;
          seq_done_nx = 1'b0;
        end
      end

      ST_TEARDOWN: begin
        // Dropping the top bit of a thermometer code is a right shift.
        tmr_clr      = 1'b1;
        stage_rst_nx = {1'b0, stage_rst_n[NUM_STAGES-1:1]};
        if (stage_rst_n[NUM_STAGES-1:1] == '0) begin
          state_nx = ST_HOLD;
          idx_nx   = '0;
        end
      end

      ST_FAULT: begin
        tmr_clr = 1'b1;
        if (sw_reset_req) begin
          state_nx = ST_HOLD;
          fault_nx = 1'b0;
          idx_nx   = '0;
        end
      end

      default: begin
        state_nx     = ST_HOLD;
        idx_nx       = '0;
        stage_rst_nx = '0;
        seq_done_nx  = 1'b0;
        tmr_clr      = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_reset_sequencer                                         |
// | Purpose : Scoreboard testbench for reset_sequencer: directed         |
// |           scenarios plus randomized lock/request/ack traffic,        |
// |           compared each cycle against a behavioural model.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_reset_sequencer;

  localparam int NS = 4;
  localparam int SD = 16;
  localparam int AT = 1024;
  localparam int IW = 2;

  localparam int P_HOLD = 0, P_WAIT = 1, P_GAP = 2, P_RUN = 3, P_TD = 4, P_FAULT = 5;

  logic          clk = 1'b0;
  logic          sync_rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic [NS-1:0] stage_ack = '0;
  logic [NS-1:0] stage_rst_n;
  logic          seq_done;
  logic          fault;
  logic [IW-1:0] fault_stage;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES  (NS),
    .STAGE_DELAY (SD),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk          (clk),
    .sync_rst_n   (sync_rst_n),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .stage_ack    (stage_ack),
    .stage_rst_n  (stage_rst_n),
    .seq_done     (seq_done),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  // Behavioural model: number of released stages plus a phase and a counter.
  int m_phase = P_HOLD, m_rel = 0, m_cnt = 0, m_done = 0, m_flt = 0, m_fst = 0;

  // Ack generator state.
  int age[NS];
  int ack_dly[NS];
  bit ack_en[NS];
  bit noise = 0;
  bit rand_mode = 0;
  bit sw_on_ack1 = 0;

  task automatic model_step(input bit rstn, input bit lock, input bit sw, input logic [NS-1:0] a);
    bit ab;
    ab = !lock || sw;
    if (!rstn) begin
      m_phase = P_HOLD; m_rel = 0; m_cnt = 0; m_done = 0; m_flt = 0; m_fst = 0;
    end else begin
      case (m_phase)
        P_HOLD: begin
          if (ab) m_cnt = 0;
          else if (m_cnt == SD - 1) begin m_phase = P_WAIT; m_rel = 1; m_cnt = 0; end
          else m_cnt++;
        end
        P_WAIT: begin
          if (ab) begin m_phase = P_TD; m_done = 0; end
          else if (a[m_rel-1]) begin
            m_cnt = 0;
            if (m_rel == NS) begin m_phase = P_RUN; m_done = 1; end
            else m_phase = P_GAP;
          end else if (m_cnt == AT - 1) begin
            m_phase = P_FAULT; m_flt = 1; m_fst = m_rel - 1; m_rel = 0; m_done = 0;
          end else m_cnt++;
        end
        P_GAP: begin
          if (ab) begin m_phase = P_TD; m_done = 0; end
          else if (m_cnt == SD - 1) begin m_phase = P_WAIT; m_rel++; m_cnt = 0; end
          else m_cnt++;
        end
        P_RUN: begin
          if (ab) begin m_phase = P_TD; m_done = 0; end
        end
        P_TD: begin
          m_cnt = 0;
          if (m_rel > 0) m_rel--;
          if (m_rel == 0) m_phase = P_HOLD;
        end
        default: begin
          m_cnt = 0;
          if (sw) begin m_phase = P_HOLD; m_flt = 0; end
        end
      endcase
    end
  endtask

  // One clock: drive inputs after the falling edge, advance the model, queue the expectation.
  task automatic step(input bit rstn, input bit lock, input bit sw);
    logic [NS-1:0] a;
    logic [NS-1:0] th;
    bit sw_eff;
    @(negedge clk);
    sw_eff = sw;
    a = '0;
    for (int k = 0; k < NS; k++) begin
      if (ack_en[k] && k < m_rel && age[k] >= ack_dly[k]) a[k] = 1'b1;
      if (noise && (k >= m_rel || m_phase == P_RUN) && $urandom_range(0, 3) == 0) a[k] = ~a[k];
    end
    if (sw_on_ack1 && m_phase == P_WAIT && m_rel == 2 && a[1]) begin
      sw_eff = 1'b1;
      sw_on_ack1 = 1'b0;
    end
    sync_rst_n   = rstn;
    pll_locked   = lock;
    sw_reset_req = sw_eff;
    stage_ack    = a;
    model_step(rstn, lock, sw_eff, a);
    th = NS'((1 << m_rel) - 1);
    exp_q.push_back({th, 1'(m_done), 1'(m_flt), IW'(m_fst)});
    for (int k = 0; k < NS; k++) begin
      if (k < m_rel) age[k]++;
      else begin
        age[k] = 0;
        if (rand_mode) begin
          ack_dly[k] = $urandom_range(0, 12);
          ack_en[k]  = ($urandom_range(0, 15) != 0);
        end
      end
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (m_phase != target && n < budget) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (m_phase != target) begin
      checks++;
      errors++;
      $display("FAIL reach_phase: model phase %0d, required %0d within %0d cycles", m_phase, target, budget);
    end
  endtask

  // Monitor: outputs are always presented, so one expectation is consumed per edge.
  logic [7:0] mon_exp, mon_act;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {stage_rst_n, seq_done, fault, fault_stage};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got rst_n=%b done=%b fault=%b stage=%0d, expected rst_n=%b done=%b fault=%b stage=%0d",
                   cyc, mon_act[7:4], mon_act[3], mon_act[2], mon_act[1:0],
                   mon_exp[7:4], mon_exp[3], mon_exp[2], mon_exp[1:0]);
        end
      end
    end
  end

  initial begin
    int rise;
    for (int k = 0; k < NS; k++) begin
      age[k] = 0; ack_dly[k] = 3; ack_en[k] = 1'b1;
    end

    // 1: reset values, then clean bring-up with acks 3 cycles after release.
    repeat (3) step(1'b0, 1'b1, 1'b0);
    rise = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      if (stage_rst_n[0] === 1'b1 && rise == 0) rise = n;
    end
    checks++;
    if (rise != SD) begin
      errors++;
      $display("FAIL first_release_edge: got %0d, expected %0d", rise, SD);
    end
    run_until(P_RUN, 200);
    repeat (5) step(1'b1, 1'b1, 1'b0);

    // 4: lock loss in RUN tears down one stage per edge.
    repeat (7) step(1'b1, 1'b0, 1'b0);

    // 2: lock glitch during debounce.
    repeat (10) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_until(P_RUN, 300);

    // 3: stage 2 never acks -> timeout fault; lock is ignored; request clears.
    ack_en[2] = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    run_until(P_FAULT, 3000);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    ack_en[2] = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    run_until(P_RUN, 300);

    // 5: software request on the same edge as ack[1].
    step(1'b1, 1'b0, 1'b0);
    run_until(P_HOLD, 10);
    sw_on_ack1 = 1'b1;
    run_until(P_TD, 300);
    run_until(P_HOLD, 10);

    // 6: reset asserted mid-GAP.
    run_until(P_GAP, 100);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    run_until(P_RUN, 300);

    // Randomized traffic with ack noise on ignored bits.
    noise = 1'b1;
    rand_mode = 1'b1;
    for (int n = 0; n < 8000; n++) begin
      step($urandom_range(0, 599) != 0, $urandom_range(0, 199) != 0, $urandom_range(0, 249) == 0);
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
